// File: rtl/sw_input_req_if.sv
// Router types and the switch-allocation requester bundle.
// router_pkg: dir_t, NUM_VCS. sw_input_req_if: VC buffer, credit, grant, ST.
package router_pkg;
    typedef enum logic [2:0] {
        DIR_N = 3'd0,
        DIR_E = 3'd1,
        DIR_S = 3'd2,
        DIR_W = 3'd3,
        DIR_L = 3'd4
    } dir_t;

    localparam int NUM_VCS = 4;
endpackage

// Ports (per VC unless noted):
//  master drives flit_valid/head/tail, route_in, credit_avail, grant
//  slave  drives reqsa, route_out, pop, st_valid/st_vc/st_dir (scalar)
interface sw_input_req_if #(
    parameter int NVC = router_pkg::NUM_VCS
) ();
    import router_pkg::*;

    localparam int VW = (NVC > 1) ? $clog2(NVC) : 1;

    logic [NVC-1:0] flit_valid;
    logic [NVC-1:0] flit_head;
    logic [NVC-1:0] flit_tail;
    dir_t [NVC-1:0] route_in;
    logic [NVC-1:0] credit_avail;
    logic [NVC-1:0] grant;
    dir_t [NVC-1:0] reqsa;
    dir_t [NVC-1:0] route_out;
    logic [NVC-1:0] pop;
    logic           st_valid;
    logic [VW-1:0]  st_vc;
    dir_t           st_dir;

    modport master (
        output flit_valid, flit_head, flit_tail,
        output route_in, credit_avail, grant,
        input  reqsa, route_out, pop,
        input  st_valid, st_vc, st_dir
    );

    modport slave (
        input  flit_valid, flit_head, flit_tail,
        input  route_in, credit_avail, grant,
        output reqsa, route_out, pop,
        output st_valid, st_vc, st_dir
    );
endinterface

// File: rtl/sw_input_req.sv
// Input-first SA requester: per-VC packet FSM, RR VC pick, pop, ST register.
// Ports: clk, arst (async active-high), io (sw_input_req_if.slave).
module sw_input_req
    import router_pkg::*;
#(
    parameter dir_t INPUT_PORT = DIR_E,
    parameter int   NVC        = NUM_VCS
) (
    input  logic          clk,
    input  logic          arst,
    sw_input_req_if.slave io
);
    localparam int VW = (NVC > 1) ? $clog2(NVC) : 1;

    typedef enum logic {IDLE, ACTIVE} vc_st_t;

    vc_st_t         st_q [NVC];
    vc_st_t         st_d [NVC];
    dir_t [NVC-1:0] route_q;
    logic [VW-1:0]  rr_q;

    logic [NVC-1:0] elig;
    logic [NVC-1:0] ld;
    logic [NVC-1:0] pop;
    logic [NVC-1:0] sel_oh;
    logic [NVC-1:0] hd_err;
    logic           gnt_err;
    logic [VW-1:0]  sel;
    logic [VW-1:0]  sel_nx;
    logic           any;
    logic [VW:0]    cand;

    logic           st_valid_q;
    logic [VW-1:0]  st_vc_q;
    dir_t           st_dir_q;

    always_comb begin
        for (int v = 0; v < NVC; v++) begin
            elig[v]   = (st_q[v] == ACTIVE)
                      & io.flit_valid[v]
                      & io.credit_avail[v];
            ld[v]     = (st_q[v] == IDLE)
                      & io.flit_valid[v]
                      & io.flit_head[v];
            hd_err[v] = (st_q[v] == IDLE)
                      & io.flit_valid[v]
                      & ~io.flit_head[v];
        end
    end

    // First eligible VC at or after rr, wrapping.
    always_comb begin
        any  = 1'b0;
        sel  = '0;
        cand = '0;
        for (int i = 0; i < NVC; i++) begin
            cand = {1'b0, rr_q} + (VW+1)'(i);
            if (cand >= (VW+1)'(NVC))
                cand = cand - (VW+1)'(NVC);
            if (!any && elig[cand[VW-1:0]]) begin
                any = 1'b1;
                sel = cand[VW-1:0];
            end
        end
    end

    assign sel_nx = (sel == VW'(NVC-1)) ? '0
                  : sel + VW'(1);

    always_comb begin
        for (int v = 0; v < NVC; v++) begin
            sel_oh[v]   = any & (sel == VW'(v));
            pop[v]      = sel_oh[v] & io.grant[v];
            io.reqsa[v] = sel_oh[v] ? route_q[v]
                                    : INPUT_PORT;
        end
        gnt_err = any & (|(io.grant & ~sel_oh));
    end

    always_comb begin
        for (int v = 0; v < NVC; v++) begin
            st_d[v] = st_q[v];
            unique case (st_q[v])
                IDLE: begin
                    if (ld[v])
                        st_d[v] = ACTIVE;
                end
                ACTIVE: begin
                    if (pop[v] && io.flit_tail[v])
                        st_d[v] = IDLE;
                end
                default: st_d[v] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int v = 0; v < NVC; v++) begin
                st_q[v]    <= IDLE;
                route_q[v] <= INPUT_PORT;
            end
            rr_q       <= '0;
            st_valid_q <= 1'b0;
            st_vc_q    <= '0;
            st_dir_q   <= INPUT_PORT;
        end else begin
            for (int v = 0; v < NVC; v++) begin
                st_q[v] <= st_d[v];
                if (ld[v])
                    route_q[v] <= io.route_in[v];
            end
            st_valid_q <= |pop;
            if (|pop) begin
                rr_q     <= sel_nx;
                st_vc_q  <= sel;
                st_dir_q <= route_q[sel];
            end
            // Body flit at the head of an idle VC: protocol error.
            assert (hd_err == '0);
            // Grant to a VC other than the requesting one.
            assert (!gnt_err);
        end
    end

    assign io.pop       = pop;
    assign io.route_out = route_q;
    assign io.st_valid  = st_valid_q;
    assign io.st_vc     = st_vc_q;
    assign io.st_dir    = st_dir_q;
endmodule

// File: tb/tb_sw_input_req.sv
// Bench for sw_input_req: packet-queue model of the VC buffers,
// directed scenarios then randomized traffic, credit and grants.
module tb_sw_input_req;
    import router_pkg::*;

    localparam int NVC = 4;

    logic clk;
    logic arst;

    sw_input_req_if #(.NVC(NVC)) ifc ();

    sw_input_req #(
        .INPUT_PORT (DIR_E),
        .NVC        (NVC)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .io   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    // Buffer contents per VC: {head, tail, dir[2:0]}
    logic [4:0] q [NVC][$];

    logic       m_act   [NVC];
    logic [2:0] m_route [NVC];
    int         m_rr;
    logic       m_stv;
    int         m_stvc;
    logic [2:0] m_stdir;

    logic [NVC-1:0] cr;
    int             gmode;
    bit             noise;

    logic [2:0] rtab [4] = '{3'd0, 3'd2, 3'd3, 3'd4};

    task automatic chk(string tag, logic [31:0] obs,
                       logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NVC; v++) begin
            q[v].delete();
            m_act[v]   = 1'b0;
            m_route[v] = 3'(DIR_E);
        end
        m_rr    = 0;
        m_stv   = 1'b0;
        m_stvc  = 0;
        m_stdir = 3'(DIR_E);
    endtask

    task automatic push_pkt(int vc, int len,
                            logic [2:0] d);
        for (int i = 0; i < len; i++)
            q[vc].push_back({i == 0, i == len - 1, d});
    endtask

    task automatic chk_all(string tag, int sel,
                           logic g);
        logic [3*NVC-1:0] ereq;
        logic [3*NVC-1:0] ert;
        logic [NVC-1:0]   epop;
        for (int v = 0; v < NVC; v++) begin
            ereq[v*3 +: 3] = (v == sel) ? m_route[v]
                                        : 3'(DIR_E);
            ert[v*3 +: 3]  = m_route[v];
            epop[v]        = (v == sel) && g;
        end
        chk({tag, ".reqsa"}, 32'(ifc.reqsa), 32'(ereq));
        chk({tag, ".pop"}, 32'(ifc.pop), 32'(epop));
        chk({tag, ".route"}, 32'(ifc.route_out),
            32'(ert));
        chk({tag, ".stv"}, 32'(ifc.st_valid),
            32'(m_stv));
        chk({tag, ".stvc"}, 32'(ifc.st_vc),
            32'(m_stvc));
        chk({tag, ".stdir"}, 32'(ifc.st_dir),
            32'(m_stdir));
    endtask

    task automatic step(string tag);
        int         sel;
        int         best;
        int         d;
        logic       g;
        logic       vld [NVC];
        logic [4:0] hf  [NVC];
        @(negedge clk);
        for (int v = 0; v < NVC; v++) begin
            vld[v] = q[v].size() > 0;
            hf[v]  = vld[v] ? q[v][0] : 5'h04;
            ifc.flit_valid[v] = vld[v];
            ifc.flit_head[v]  = hf[v][4];
            ifc.flit_tail[v]  = hf[v][3];
            ifc.route_in[v]   = dir_t'(hf[v][2:0]);
        end
        ifc.credit_avail = cr;
        sel  = -1;
        best = NVC;
        for (int v = 0; v < NVC; v++) begin
            if (m_act[v] && vld[v] && cr[v]) begin
                d = (v - m_rr + NVC) % NVC;
                if (d < best) begin
                    best = d;
                    sel  = v;
                end
            end
        end
        g = 1'b0;
        if (sel >= 0)
            g = (gmode == 1) || (gmode == 2 &&
                $urandom_range(0, 2) != 0);
        ifc.grant = '0;
        if (sel >= 0 && g)
            ifc.grant[sel] = 1'b1;
        else if (sel < 0 && noise)
            ifc.grant = NVC'($urandom);
        #1;
        chk_all(tag, sel, g);
        // Advance the model past the next rising edge.
        for (int v = 0; v < NVC; v++) begin
            if (!m_act[v] && vld[v] && hf[v][4]) begin
                m_act[v]   = 1'b1;
                m_route[v] = hf[v][2:0];
            end else if (m_act[v] && g && v == sel &&
                         hf[v][3]) begin
                m_act[v] = 1'b0;
            end
        end
        m_stv = (sel >= 0) && g;
        if (m_stv) begin
            m_stvc  = sel;
            m_stdir = m_route[sel];
            m_rr    = (sel + 1) % NVC;
            void'(q[sel].pop_front());
        end
    endtask

    task automatic run(string tag, int n);
        for (int i = 0; i < n; i++)
            step(tag);
    endtask

    task automatic do_reset(string tag);
        @(negedge clk);
        #3;
        arst = 1'b1;
        model_reset();
        #1;
        chk_all(tag, -1, 1'b0);
        ifc.flit_valid = '0;
        ifc.grant      = '0;
        @(negedge clk);
        arst = 1'b0;
    endtask

    initial begin
        arst             = 1'b1;
        ifc.flit_valid   = '0;
        ifc.flit_head    = '0;
        ifc.flit_tail    = '0;
        ifc.credit_avail = '0;
        ifc.grant        = '0;
        for (int v = 0; v < NVC; v++)
            ifc.route_in[v] = DIR_L;
        cr    = '1;
        gmode = 1;
        noise = 1'b0;
        model_reset();
        #2;
        chk_all("rst0", -1, 1'b0);
        @(negedge clk);
        arst = 1'b0;

        push_pkt(0, 1, 3'(DIR_N));
        run("t1", 4);

        push_pkt(0, 4, 3'(DIR_S));
        push_pkt(1, 4, 3'(DIR_W));
        run("t2", 12);

        push_pkt(0, 2, 3'(DIR_L));
        cr[0] = 1'b0;
        run("t3off", 6);
        cr[0] = 1'b1;
        run("t3on", 4);

        push_pkt(1, 1, 3'(DIR_W));
        gmode = 0;
        run("t4hold", 4);
        gmode = 1;
        run("t4go", 3);

        push_pkt(0, 4, 3'(DIR_N));
        push_pkt(0, 1, 3'(DIR_S));
        run("t5", 10);

        noise = 1'b1;
        gmode = 0;
        run("nogrq", 3);
        gmode = 1;

        push_pkt(2, 4, 3'(DIR_W));
        push_pkt(3, 3, 3'(DIR_N));
        run("t6pre", 4);
        do_reset("t6rst");
        push_pkt(2, 1, 3'(DIR_L));
        run("t6post", 5);

        gmode = 2;
        for (int c = 0; c < 600; c++) begin
            for (int v = 0; v < NVC; v++)
                if (q[v].size() < 6 &&
                    $urandom_range(0, 5) == 0)
                    push_pkt(v, $urandom_range(1, 4),
                             rtab[$urandom_range(0, 3)]);
            cr = NVC'($urandom | $urandom);
            step("rnd");
            if (c == 300)
                do_reset("rndrst");
        end

        $display("[TB] %0d tests run, %0d failed",
                 ntests, nfail);
        $finish;
    end
endmodule
